// File: rtl/clk_gen_pkg.sv
// Shared types and constants for the processor clock-phase generator.
// The phase constants name which derived clock owns each quarter of a processor cycle.
package clk_gen_pkg;

    localparam int PHASE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam logic [PHASE_W-1:0] PH_PC   = 2'd0;
    localparam logic [PHASE_W-1:0] PH_IMEM = 2'd1;
    localparam logic [PHASE_W-1:0] PH_REG  = 2'd2;
    localparam logic [PHASE_W-1:0] PH_DMEM = 2'd3;

endpackage

// File: rtl/phase_counter.sv
// Two-bit phase register that walks 0..3 while enabled and sits at 0 otherwise.
// phase_next is exported so the parent can register outputs aligned with the phase.
module phase_counter
    import clk_gen_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               en,
    output logic [PHASE_W-1:0] phase,
    output logic [PHASE_W-1:0] phase_next,
    output logic               last_phase
);

    logic [PHASE_W-1:0] phase_reg;

    always_comb begin
        phase_next = PH_PC;
        if (en) begin
            phase_next = PHASE_W'(phase_reg + 1'b1);
        end
    end

    assign last_phase = en && (phase_reg == PH_DMEM);
    assign phase      = phase_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_reg <= PH_PC;
        end else begin
            phase_reg <= phase_next;
        end
    end

endmodule

// File: rtl/clock_phase_gen.sv
// Generates the four-phase processor clocks with free-run and single-step control.
// Derived clocks are registered from the next state/phase so they line up with the phase output.
module clock_phase_gen
    import clk_gen_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run_en,
    input  logic               step_req,
    output logic               PC_clk,
    output logic               imem_clock,
    output logic               regfile_clock,
    output logic               processor_clock,
    output logic               dmem_clock,
    output logic [PHASE_W-1:0] phase,
    output logic [COUNT_W-1:0] cycle_count,
    output logic               step_done
);

    state_t             state_reg, state_next;
    logic [PHASE_W-1:0] phase_next;
    logic               last_phase;
    logic               active;

    logic pc_clk_reg, imem_reg, regfile_reg, proc_reg, dmem_reg, step_done_reg;
    logic pc_clk_next, imem_next, regfile_next, proc_next, dmem_next, step_done_next;
    logic [COUNT_W-1:0] cycle_count_reg;

    assign active = (state_reg != IDLE);

    phase_counter u_phase_counter (
        .clock      (clock),
        .reset      (reset),
        .en         (active),
        .phase      (phase),
        .phase_next (phase_next),
        .last_phase (last_phase)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Leaving RUN or STEP only happens on the edge that closes phase 3.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (run_en) begin
                    state_next = RUN;
                end else if (step_req) begin
                    state_next = STEP;
                end
            end
            RUN, STEP: begin
                if (last_phase) begin
                    state_next = run_en ? RUN : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pc_clk_next    = 1'b0;
        imem_next      = 1'b0;
        regfile_next   = 1'b0;
        proc_next      = 1'b0;
        dmem_next      = 1'b0;
        step_done_next = (state_reg == STEP) && last_phase;
        if (state_next != IDLE) begin
            pc_clk_next  = (phase_next == PH_PC);
            imem_next    = (phase_next == PH_IMEM);
            regfile_next = (phase_next == PH_REG);
            proc_next    = (phase_next == PH_REG) || (phase_next == PH_DMEM);
            dmem_next    = (phase_next == PH_DMEM);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_clk_reg      <= 1'b0;
            imem_reg        <= 1'b0;
            regfile_reg     <= 1'b0;
            proc_reg        <= 1'b0;
            dmem_reg        <= 1'b0;
            step_done_reg   <= 1'b0;
            cycle_count_reg <= '0;
        end else begin
            pc_clk_reg    <= pc_clk_next;
            imem_reg      <= imem_next;
            regfile_reg   <= regfile_next;
            proc_reg      <= proc_next;
            dmem_reg      <= dmem_next;
            step_done_reg <= step_done_next;
            if (last_phase) begin
                cycle_count_reg <= cycle_count_reg + COUNT_W'(1);
            end
        end
    end

    assign PC_clk          = pc_clk_reg;
    assign imem_clock      = imem_reg;
    assign regfile_clock   = regfile_reg;
    assign processor_clock = proc_reg;
    assign dmem_clock      = dmem_reg;
    assign step_done       = step_done_reg;
    assign cycle_count     = cycle_count_reg;

endmodule

// File: tb/tb_clock_phase_gen.sv
// Scoreboard bench for clock_phase_gen: a cycle-level model predicts every output per clock.
// A narrow COUNT_W makes the cycle_count wrap reachable within a short run.
module tb_clock_phase_gen;

    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset, run_en, step_req;
    logic          PC_clk, imem_clock, regfile_clock, processor_clock, dmem_clock, step_done;
    logic [1:0]    phase;
    logic [CW-1:0] cycle_count;

    typedef struct packed {
        logic [1:0]    ph;
        logic          pc, im, rf, pr, dm, done;
        logic [CW-1:0] cnt;
    } obs_t;

    obs_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model state: whether a processor cycle is in flight, which quarter, and if it is a step.
    bit busy = 0, is_step = 0, done = 0;
    int pos = 0, count = 0;

    clock_phase_gen #(.COUNT_W(CW)) dut (
        .clock           (clock),
        .reset           (reset),
        .run_en          (run_en),
        .step_req        (step_req),
        .PC_clk          (PC_clk),
        .imem_clock      (imem_clock),
        .regfile_clock   (regfile_clock),
        .processor_clock (processor_clock),
        .dmem_clock      (dmem_clock),
        .phase           (phase),
        .cycle_count     (cycle_count),
        .step_done       (step_done)
    );

    always #5 clock = ~clock;

    function automatic obs_t expected();
        obs_t e;
        e.ph   = 2'(pos);
        e.pc   = busy && pos == 0;
        e.im   = busy && pos == 1;
        e.rf   = busy && pos == 2;
        e.pr   = busy && pos >= 2;
        e.dm   = busy && pos == 3;
        e.done = done;
        e.cnt  = CW'(count);
        return e;
    endfunction

    task automatic model_edge(input bit r, input bit ru, input bit st);
        if (r) begin
            busy = 0; pos = 0; count = 0; done = 0;
        end else if (!busy) begin
            done = 0;
            if (ru) begin
                busy = 1; is_step = 0; pos = 0;
            end else if (st) begin
                busy = 1; is_step = 1; pos = 0;
            end
        end else if (pos == 3) begin
            count = (count + 1) % (1 << CW);
            done  = is_step;
            pos   = 0;
            busy  = ru;
            is_step = 0;
        end else begin
            pos  = pos + 1;
            done = 0;
        end
    endtask

    // Apply inputs for one clock; the model sees the same values the DUT samples.
    task automatic drive(input bit r, input bit ru, input bit st);
        reset = r; run_en = ru; step_req = st;
        @(posedge clock);
        model_edge(r, ru, st);
        sb.push_back(expected());
        #1;
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(negedge clock);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                a = '{phase, PC_clk, imem_clock, regfile_clock, processor_clock,
                      dmem_clock, step_done, cycle_count};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t actual ph=%0d pc=%b im=%b rf=%b pr=%b dm=%b done=%b cnt=%0d required ph=%0d pc=%b im=%b rf=%b pr=%b dm=%b done=%b cnt=%0d",
                             $time, a.ph, a.pc, a.im, a.rf, a.pr, a.dm, a.done, a.cnt,
                             e.ph, e.pc, e.im, e.rf, e.pr, e.dm, e.done, e.cnt);
                end
            end
        end
    end

    initial begin : stimulus
        bit ru;
        repeat (3) drive(1, 0, 0);
        drive(1, 1, 1);                          // reset beats run/step
        $display("scenario free-run 12 clocks");
        repeat (12) drive(0, 1, 0);
        repeat (4) drive(0, 0, 0);
        $display("scenario single step");
        drive(0, 0, 1);
        repeat (7) drive(0, 0, 0);
        $display("scenario run_en dropped in phase 1");
        drive(0, 1, 0);
        drive(0, 1, 0);
        repeat (6) drive(0, 0, 0);
        $display("scenario run and step together, step pulses in run");
        drive(0, 1, 1);
        repeat (3) begin
            drive(0, 1, 1);
            drive(0, 1, 0);
        end
        repeat (5) drive(0, 0, 0);
        $display("scenario step then run_en at phase 3");
        drive(0, 0, 1);
        drive(0, 0, 0);
        drive(0, 0, 0);
        repeat (6) drive(0, 1, 0);
        $display("scenario reset in phase 2");
        drive(0, 1, 0);
        drive(0, 1, 0);
        drive(1, 1, 0);
        drive(0, 0, 0);
        $display("scenario run past cycle_count wrap");
        repeat (4 * ((1 << CW) + 2)) drive(0, 1, 0);
        repeat (4) drive(0, 0, 0);
        $display("scenario random");
        ru = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) ru = ~ru;
            drive($urandom_range(0, 99) == 0, ru, $urandom_range(0, 7) == 0);
        end
        @(negedge clock);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual %0d pending required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
